// File: rtl/ctrl_pkg.sv
// Shared types and helpers for the memory-port arbiter: FSM states, grant
// decision record and beat-size helpers.
package ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    DM_ACC = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic if_win;
    logic dm_win;
  } arb_grant_t;

  localparam int MEM_DATA_W = 32;
  localparam int BEAT_BYTES = MEM_DATA_W / 8;

  function automatic int beat_bytes(input int data_w);
    return data_w / 8;
  endfunction

  // DM is the older instruction and normally wins; an owed IF overrides it once.
  function automatic arb_grant_t arbitrate(input logic if_req,
                                           input logic dm_req,
                                           input logic if_owed);
    arb_grant_t g;
    g.dm_win = dm_req & ~(if_owed & if_req);
    g.if_win = if_req & ~g.dm_win;
    return g;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data-access and memory-port signals around mem_arbiter.
// slave = the arbiter itself, master = the surrounding pipeline/memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
);
  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              o_if_gnt;
  logic              o_if_valid;
  logic [DATA_W-1:0] o_if_rdata;
  logic              o_stall_if;

  logic              i_dm_req;
  logic              i_dm_we;
  logic [ADDR_W-1:0] i_dm_addr;
  logic [LEN_W-1:0]  i_dm_len;
  logic [DATA_W-1:0] i_dm_wdata;
  logic              o_dm_gnt;
  logic              o_dm_wnext;
  logic              o_dm_valid;
  logic [DATA_W-1:0] o_dm_rdata;
  logic              o_dm_done;

  logic              o_mem_en;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              i_mem_ready;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_gnt, o_if_valid, o_if_rdata, o_stall_if,
    input  i_dm_req, i_dm_we, i_dm_addr, i_dm_len, i_dm_wdata,
    output o_dm_gnt, o_dm_wnext, o_dm_valid, o_dm_rdata, o_dm_done,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_rdata, i_mem_ready
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_gnt, o_if_valid, o_if_rdata, o_stall_if,
    output i_dm_req, i_dm_we, i_dm_addr, i_dm_len, i_dm_wdata,
    input  o_dm_gnt, o_dm_wnext, o_dm_valid, o_dm_rdata, o_dm_done,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_rdata, i_mem_ready
  );
endinterface

// File: rtl/arb_burst_cnt.sv
// Burst address/beat tracker: loads a start address and beat count, steps
// both on every completed beat and flags the final beat.
module arb_burst_cnt
  import ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4,
  parameter int STEP   = BEAT_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] addr_reg;
  logic [LEN_W-1:0]  cnt_reg;

  // A load coincides with the final advance on back-to-back grants; load wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_reg <= '0;
      cnt_reg  <= '0;
    end else if (load) begin
      addr_reg <= load_addr;
      cnt_reg  <= (load_len == '0) ? LEN_W'(1) : load_len;
    end else if (advance) begin
      addr_reg <= addr_reg + ADDR_W'(STEP);
      if (cnt_reg != '0) begin
        cnt_reg <= cnt_reg - LEN_W'(1);
      end
    end
  end

  assign addr = addr_reg;
  assign last = (cnt_reg == LEN_W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Single memory port shared between instruction fetch and MEM-stage data
// bursts; DM has priority, with a one-shot fairness token for a starved IF.
module mem_arbiter
  import ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  arb_state_t state_reg, state_next;
  logic       if_owed_reg, if_owed_next;
  logic       we_reg, we_next;

  logic              if_valid_reg;
  logic [DATA_W-1:0] if_rdata_reg;
  logic              dm_valid_reg;
  logic [DATA_W-1:0] dm_rdata_reg;
  logic              dm_done_reg;

  logic              mem_en;
  logic              beat_done;
  logic              cnt_last;
  logic              last_beat;
  logic              arb_cycle;
  arb_grant_t        grant;
  logic              if_gnt;
  logic              dm_gnt;
  logic              load;
  logic [ADDR_W-1:0] load_addr;
  logic [LEN_W-1:0]  load_len;
  logic [ADDR_W-1:0] cnt_addr;

  assign mem_en    = (state_reg != IDLE);
  assign beat_done = mem_en & bus.i_mem_ready;
  assign last_beat = beat_done & cnt_last;
  assign arb_cycle = (state_reg == IDLE) | last_beat;
  assign grant     = arbitrate(bus.i_if_req, bus.i_dm_req, if_owed_reg);

  // Grants are combinational from requests, so mask them while reset is held.
  assign if_gnt = rst & arb_cycle & grant.if_win;
  assign dm_gnt = rst & arb_cycle & grant.dm_win;

  always_comb begin
    state_next   = state_reg;
    we_next      = we_reg;
    if_owed_next = if_owed_reg;
    load         = 1'b0;
    load_addr    = '0;
    load_len     = '0;

    if (arb_cycle) begin
      if (dm_gnt) begin
        state_next = DM_ACC;
        we_next    = bus.i_dm_we;
        load       = 1'b1;
        load_addr  = bus.i_dm_addr;
        load_len   = bus.i_dm_len;
      end else if (if_gnt) begin
        state_next = IF_ACC;
        we_next    = 1'b0;
        load       = 1'b1;
        load_addr  = bus.i_if_addr;
        load_len   = LEN_W'(1);
      end else begin
        state_next = IDLE;
        we_next    = 1'b0;
      end
    end

    if (if_gnt) begin
      if_owed_next = 1'b0;
    end else if ((state_reg == DM_ACC) && last_beat && bus.i_if_req) begin
      if_owed_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      if_owed_reg <= 1'b0;
      we_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      if_owed_reg <= if_owed_next;
      we_reg      <= we_next;
    end
  end

  // Read data and completion pulses appear the cycle after the beat completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_valid_reg <= 1'b0;
      if_rdata_reg <= '0;
      dm_valid_reg <= 1'b0;
      dm_rdata_reg <= '0;
      dm_done_reg  <= 1'b0;
    end else begin
      if_valid_reg <= (state_reg == IF_ACC) & beat_done;
      dm_valid_reg <= (state_reg == DM_ACC) & beat_done & ~we_reg;
      dm_done_reg  <= (state_reg == DM_ACC) & last_beat;
      if ((state_reg == IF_ACC) && beat_done) begin
        if_rdata_reg <= bus.i_mem_rdata;
      end
      if ((state_reg == DM_ACC) && beat_done && !we_reg) begin
        dm_rdata_reg <= bus.i_mem_rdata;
      end
    end
  end

  arb_burst_cnt #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W),
    .STEP   (beat_bytes(DATA_W))
  ) u_burst_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_addr (load_addr),
    .load_len  (load_len),
    .advance   (beat_done),
    .addr      (cnt_addr),
    .last      (cnt_last)
  );

  assign bus.o_if_gnt    = if_gnt;
  assign bus.o_if_valid  = if_valid_reg;
  assign bus.o_if_rdata  = if_rdata_reg;
  assign bus.o_stall_if  = rst & bus.i_if_req & ((state_reg != IF_ACC) | ~beat_done);

  assign bus.o_dm_gnt    = dm_gnt;
  assign bus.o_dm_wnext  = (state_reg == DM_ACC) & we_reg & beat_done & ~cnt_last;
  assign bus.o_dm_valid  = dm_valid_reg;
  assign bus.o_dm_rdata  = dm_rdata_reg;
  assign bus.o_dm_done   = dm_done_reg;

  assign bus.o_mem_en    = mem_en;
  assign bus.o_mem_we    = (state_reg == DM_ACC) & we_reg;
  assign bus.o_mem_addr  = cnt_addr;
  assign bus.o_mem_wdata = bus.i_dm_wdata;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single memory port between instruction fetch (IF) and the MEM-stage data access, and sequences multi-beat data transfers. It sits between the fetch unit, the MEM-stage control and the memory. It uses the same beat count that ID computes for the stall controller. The block also drives a fetch stall whenever IF is waiting for the port.

## Interface
Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, memory word width.
- LEN_W, 4, width of the data beat count (matches the `mem_data_access` field).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_if_req  in  1  fetch request; held until o_if_gnt.
- i_if_addr  in  ADDR_W  fetch address.
- o_if_gnt  out  1  one-cycle pulse: the IF request is accepted.
- o_if_valid  out  1  one-cycle pulse: o_if_rdata holds fetched data.
- o_if_rdata  out  DATA_W  fetch data.
- o_stall_if  out  1  IF is pending and not yet served.
- i_dm_req  in  1  data request; held until o_dm_gnt.
- i_dm_we  in  1  1 = write, 0 = read.
- i_dm_addr  in  ADDR_W  start address.
- i_dm_len  in  LEN_W  number of beats; 0 is treated as 1.
- i_dm_wdata  in  DATA_W  write data for the current beat.
- o_dm_gnt  out  1  one-cycle pulse: the data request is accepted.
- o_dm_wnext  out  1  the write beat is consumed; present the next wdata.
- o_dm_valid  out  1  one-cycle pulse per read beat.
- o_dm_rdata  out  DATA_W  read data.
- o_dm_done  out  1  one-cycle pulse after the last beat.
- o_mem_en  out  1  memory access active.
- o_mem_we  out  1  memory write.
- o_mem_addr  out  ADDR_W  memory address.
- o_mem_wdata  out  DATA_W  memory write data (combinational from i_dm_wdata).
- i_mem_rdata  in  DATA_W  memory read data, valid when i_mem_ready = 1.
- i_mem_ready  in  1  beat completes this cycle.

## Operation
- FSM states:
  - IDLE: no access.
  - IF_ACC: single fetch beat.
  - DM_ACC: data burst.
- Arbitration runs in IDLE and on the cycle the last beat completes.
  - DM has priority, because it is the older instruction.
  - Fairness: set the `if_owed` flag when a DM burst ends while IF was requesting. While `if_owed` is set, IF wins the next arbitration; clear the flag when IF is granted.
- Grant:
  - Pulse o_*_gnt in the arbitration cycle.
  - Register the address, direction and beat count.
  - Set o_mem_en = 1 from the next cycle.
  - Requests that deassert after the grant have no effect.
- Beats:
  - A beat completes when o_mem_en and i_mem_ready are both 1.
  - On completion, o_mem_addr += DATA_W/8 and the remaining-beat counter decrements.
  - The counter covers 1..2^LEN_W − 1 beats; it never wraps.
  - The address wraps modulo 2^ADDR_W.
- Read data: sample i_mem_rdata into o_*_rdata and pulse o_*_valid on the cycle after completion.
- Writes: pulse o_dm_wnext in the completion cycle of every write beat except the last.
- o_dm_done pulses on the cycle after the last beat completes (reads and writes).
- o_stall_if = i_if_req & (state ≠ IF_ACC or the beat has not completed).
- No requests in the arbitration cycle → IDLE with o_mem_en = 0.

## Timing
- Reset (rst = 0):
  - FSM goes to IDLE immediately.
  - All outputs, the counter and if_owed are 0; o_mem_addr = 0.
  - An in-flight burst is abandoned and not resumed.
- Grant-to-first o_mem_en latency: 1 cycle.
- Read data latency from the i_mem_ready cycle: 1 cycle.
- Back-to-back: the arbitration cycle coincides with the last-beat completion, so the next access drives o_mem_en the following cycle with no idle bubble.
- Simultaneous i_if_req and i_dm_req in IDLE with if_owed = 0 → DM is granted.
- i_mem_ready held 0 → FSM holds its state, address and counter indefinitely.

## Structure
- Shared `ctrl_pkg` holds:
  - `arb_state_t` enum (IDLE, IF_ACC, DM_ACC)
  - BEAT_BYTES = DATA_W/8
- One sub-module, `arb_burst_cnt`:
  - loads the start address and beat count
  - advances both on each completed beat
  - flags the last beat

## Test plan
- Single fetch, i_if_req at 0x100, ready on the first cycle → o_if_gnt at cycle 0, o_mem_en at cycle 1, o_if_valid with data at cycle 2.
- DM read len=4 at 0x2000, ready every cycle → o_mem_addr sequence 0x2000/4/8/C, four o_dm_valid pulses, o_dm_done once.
- IF and DM request together, DM len=2 → DM served first, then IF without a bubble, o_stall_if high until the IF beat completes.
- DM write len=3 with 2 wait states per beat → exactly 2 o_dm_wnext pulses, o_mem_we high for 9 cycles.
- Reset asserted mid-burst (beat 2 of 4) → all outputs 0 immediately; after release, a fresh IF request is granted from IDLE.
- DM len=0 → exactly one beat and o_dm_done.
